// File: rtl/cache_4way_pkg.sv
// Shared widths, FSM state type and address-field helpers for the 4-way L1 data cache.
package cache_4way_pkg;

    localparam int ADR_W       = 32;
    localparam int DATA_W      = 32;
    localparam int WORD_OFFSET = 2;
    localparam int WORDS       = 1 << WORD_OFFSET;
    localparam int INDEX_W     = 8;
    localparam int SETS        = 1 << INDEX_W;
    localparam int WAYS        = 4;
    localparam int TAG_W       = ADR_W - INDEX_W - WORD_OFFSET - 2;
    localparam int LINE_W      = DATA_W << WORD_OFFSET;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        MISS,
        RESP,
        WAIT_REL
    } state_t;

    function automatic logic [TAG_W-1:0] adr_tag(input logic [ADR_W-1:0] a);
        return a[ADR_W-1 -: TAG_W];
    endfunction

    function automatic logic [INDEX_W-1:0] adr_index(input logic [ADR_W-1:0] a);
        return a[INDEX_W+WORD_OFFSET+1 : WORD_OFFSET+2];
    endfunction

    function automatic logic [WORD_OFFSET-1:0] adr_word(input logic [ADR_W-1:0] a);
        return a[WORD_OFFSET+1 : 2];
    endfunction

endpackage

// File: rtl/cache_4way_plru.sv
// Per-set 3-bit tree pseudo-LRU: reports the victim way of a set and records accesses.
module cache_4way_plru
    import cache_4way_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [INDEX_W-1:0] idx,
    input  logic               upd_en,
    input  logic [1:0]         upd_way,
    output logic [1:0]         victim
);

    // bit0 selects the pair holding the victim (0 = ways 0/1), bit1/bit2 pick inside each pair
    logic [2:0] tree [SETS];

    assign victim = tree[idx][0] ? {1'b1, tree[idx][2]} : {1'b0, tree[idx][1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++) begin
                tree[s] <= '0;
            end
        end else if (upd_en) begin
            tree[idx][0] <= ~upd_way[1];
            if (upd_way[1]) begin
                tree[idx][2] <= ~upd_way[0];
            end else begin
                tree[idx][1] <= ~upd_way[0];
            end
        end
    end

endmodule

// File: rtl/cache_4way.sv
// 4-way set-associative write-allocate L1 data cache with a read-only word-wide refill port.
module cache_4way
    import cache_4way_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              req_cpu2cc,
    input  logic [ADR_W-1:0]  adr_cpu2cc,
    input  logic [DATA_W-1:0] dat_cpu2cc,
    input  logic              rdwr_cpu2cc,
    output logic              ack_cc2cpu,
    output logic [DATA_W-1:0] dat_cc2cpu,
    output logic              req_cc2mem,
    output logic [ADR_W-1:0]  adr_cc2mem,
    input  logic              ack_mem2cc,
    input  logic [DATA_W-1:0] dat_mem2cc,
    output logic [DATA_W-1:0] dat_mem2mshr,
    output logic [1:0]        word_mem2mshr,
    output logic [LINE_W-1:0] dat_cc2mshr
);

    state_t state, state_nxt;

    logic [ADR_W-1:0]       adr_q;
    logic [DATA_W-1:0]      dat_q;
    logic                   rdwr_q;
    logic [1:0]             way_q;
    logic [1:0]             word_cnt;
    logic [LINE_W-1:0]      line_buf;

    logic [TAG_W-1:0]       tag_mem  [WAYS][SETS];
    logic [LINE_W-1:0]      data_mem [WAYS][SETS];
    logic [WAYS-1:0]        valid    [SETS];

    logic [TAG_W-1:0]       cur_tag;
    logic [INDEX_W-1:0]     cur_idx;
    logic [WORD_OFFSET-1:0] cur_word;
    logic [WAYS-1:0]        hit_vec;
    logic                   hit;
    logic [1:0]             hit_way;
    logic                   has_invalid;
    logic [1:0]             inv_way;
    logic [1:0]             plru_victim;
    logic [1:0]             victim_way;
    logic                   refill_done;
    logic [LINE_W-1:0]      fill_line;
    logic [DATA_W-1:0]      read_word;
    logic                   adr_unused;

    assign cur_tag     = adr_tag(adr_q);
    assign cur_idx     = adr_index(adr_q);
    assign cur_word    = adr_word(adr_q);
    assign adr_unused  = ^adr_q[1:0];
    assign refill_done = (state == MISS) && ack_mem2cc && (word_cnt == 2'd3);
    assign victim_way  = has_invalid ? inv_way : plru_victim;
    assign read_word   = data_mem[way_q][cur_idx][cur_word*DATA_W +: DATA_W];

    assign req_cc2mem  = (state == MISS);
    assign adr_cc2mem  = {adr_q[ADR_W-1:WORD_OFFSET+2], word_cnt, 2'b00};
    assign dat_cc2mshr = line_buf;

    // Tag match and lowest-numbered invalid way for the latched set
    always_comb begin
        hit_way     = '0;
        inv_way     = '0;
        has_invalid = 1'b0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            hit_vec[w] = valid[cur_idx][w] && (tag_mem[w][cur_idx] == cur_tag);
            if (hit_vec[w]) begin
                hit_way = 2'(w);
            end
            if (!valid[cur_idx][w]) begin
                has_invalid = 1'b1;
                inv_way     = 2'(w);
            end
        end
        hit = |hit_vec;
    end

    always_comb begin
        fill_line = line_buf;
        fill_line[word_cnt*DATA_W +: DATA_W] = dat_mem2cc;
    end

    cache_4way_plru u_plru (
        .clk     (clk),
        .rst     (rst),
        .idx     (cur_idx),
        .upd_en  (state == RESP),
        .upd_way (way_q),
        .victim  (plru_victim)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (req_cpu2cc) state_nxt = LOOKUP;
            LOOKUP:   state_nxt = hit ? RESP : MISS;
            MISS:     if (refill_done) state_nxt = RESP;
            RESP:     state_nxt = WAIT_REL;
            WAIT_REL: if (!req_cpu2cc) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            adr_q         <= '0;
            dat_q         <= '0;
            rdwr_q        <= 1'b0;
            way_q         <= '0;
            word_cnt      <= '0;
            line_buf      <= '0;
            ack_cc2cpu    <= 1'b0;
            dat_cc2cpu    <= '0;
            dat_mem2mshr  <= '0;
            word_mem2mshr <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid[s] <= '0;
            end
        end else begin
            ack_cc2cpu <= (state == RESP);
            case (state)
                IDLE: begin
                    if (req_cpu2cc) begin
                        adr_q  <= adr_cpu2cc;
                        dat_q  <= dat_cpu2cc;
                        rdwr_q <= rdwr_cpu2cc;
                    end
                end
                LOOKUP: begin
                    way_q    <= hit ? hit_way : victim_way;
                    word_cnt <= '0;
                end
                MISS: begin
                    if (ack_mem2cc) begin
                        line_buf      <= fill_line;
                        dat_mem2mshr  <= dat_mem2cc;
                        word_mem2mshr <= word_cnt;
                        word_cnt      <= word_cnt + 2'd1;
                        if (word_cnt == 2'd3) begin
                            valid[cur_idx][way_q] <= 1'b1;
                        end
                    end
                end
                RESP: begin
                    if (!rdwr_q) begin
                        dat_cc2cpu <= read_word;
                    end
                end
                default: ;
            endcase
        end
    end

    // Storage arrays carry no reset; the valid bits alone decide whether a line exists
    always_ff @(posedge clk) begin
        if (refill_done) begin
            tag_mem[way_q][cur_idx]  <= cur_tag;
            data_mem[way_q][cur_idx] <= fill_line;
        end else if (state == RESP && rdwr_q) begin
            data_mem[way_q][cur_idx][cur_word*DATA_W +: DATA_W] <= dat_q;
        end
    end

endmodule

// File: tb/tb_cache_4way.sv
// Randomized and directed bench for cache_4way against a set/way/PLRU reference model.
module tb_cache_4way;

    localparam logic [31:0] ADR_A = 32'hFF07BD08;
    localparam logic [31:0] ADR_B = 32'hA5552D08;
    localparam logic [31:0] ADR_C = 32'hD500AD08;
    localparam logic [31:0] ADR_D = 32'hFFFFFD08;
    localparam logic [31:0] ADR_E = 32'h12345D08;

    logic         clk;
    logic         rst;
    logic         req_cpu2cc;
    logic [31:0]  adr_cpu2cc;
    logic [31:0]  dat_cpu2cc;
    logic         rdwr_cpu2cc;
    logic         ack_cc2cpu;
    logic [31:0]  dat_cc2cpu;
    logic         req_cc2mem;
    logic [31:0]  adr_cc2mem;
    logic         ack_mem2cc;
    logic [31:0]  dat_mem2cc;
    logic [31:0]  dat_mem2mshr;
    logic [1:0]   word_mem2mshr;
    logic [127:0] dat_cc2mshr;

    int total = 0;
    int bad   = 0;

    logic [31:0] mem_log[$];
    int          mem_given = 0;
    int          mem_stall_after = -1;
    int          req_mem_cycles = 0;
    time         t_last_mem_ack = 0;
    bit          ovr_en = 0;
    logic [31:0] ovr_base = 32'h0;

    bit          m_valid [256][4];
    logic [19:0] m_tag   [256][4];
    logic [31:0] m_data  [256][4][4];
    bit          m_root  [256];
    bit          m_left  [256];
    bit          m_right [256];

    cache_4way dut (
        .clk           (clk),
        .rst           (rst),
        .req_cpu2cc    (req_cpu2cc),
        .adr_cpu2cc    (adr_cpu2cc),
        .dat_cpu2cc    (dat_cpu2cc),
        .rdwr_cpu2cc   (rdwr_cpu2cc),
        .ack_cc2cpu    (ack_cc2cpu),
        .dat_cc2cpu    (dat_cc2cpu),
        .req_cc2mem    (req_cc2mem),
        .adr_cc2mem    (adr_cc2mem),
        .ack_mem2cc    (ack_mem2cc),
        .dat_mem2cc    (dat_mem2cc),
        .dat_mem2mshr  (dat_mem2mshr),
        .word_mem2mshr (word_mem2mshr),
        .dat_cc2mshr   (dat_cc2mshr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        if (ovr_en) return ovr_base + {30'd0, a[3:2]};
        return (a ^ 32'hC3A50F1E) * 32'h9E3779B1;
    endfunction

    // Read-only memory: answers refill requests with 0..2 idle cycles between words
    initial begin
        int gap;
        gap = 0;
        ack_mem2cc = 1'b0;
        dat_mem2cc = '0;
        forever begin
            @(negedge clk);
            ack_mem2cc = 1'b0;
            if (req_cc2mem && !rst) begin
                req_mem_cycles++;
                if (mem_stall_after >= 0 && mem_given >= mem_stall_after) begin
                    gap = 0;
                end else if (gap > 0) begin
                    gap--;
                end else begin
                    ack_mem2cc = 1'b1;
                    dat_mem2cc = mem_data(adr_cc2mem);
                    mem_log.push_back(adr_cc2mem);
                    mem_given++;
                    t_last_mem_ack = $time;
                    gap = $urandom_range(0, 2);
                end
            end
        end
    end

    task automatic model_reset();
        for (int s = 0; s < 256; s++) begin
            m_root[s] = 0; m_left[s] = 0; m_right[s] = 0;
            for (int w = 0; w < 4; w++) m_valid[s][w] = 0;
        end
    endtask

    // Cache behaviour from the rules: hit lookup, fill victim, merge write, mark way recent
    task automatic model_access(input logic [31:0] a, input bit wr, input logic [31:0] wd,
                                output logic [31:0] rd, output bit miss);
        int s, way;
        logic [1:0] wsel;
        s = int'(a[11:4]);
        way = -1;
        miss = 0;
        for (int w = 0; w < 4; w++)
            if (way < 0 && m_valid[s][w] && m_tag[s][w] == a[31:12]) way = w;
        if (way < 0) begin
            miss = 1;
            for (int w = 0; w < 4; w++)
                if (way < 0 && !m_valid[s][w]) way = w;
            if (way < 0) way = m_root[s] ? (m_right[s] ? 3 : 2) : (m_left[s] ? 1 : 0);
            for (int i = 0; i < 4; i++) begin
                wsel = 2'(i);
                m_data[s][way][i] = mem_data({a[31:4], wsel, 2'b00});
            end
            m_valid[s][way] = 1;
            m_tag[s][way] = a[31:12];
        end
        if (wr) m_data[s][way][a[3:2]] = wd;
        rd = m_data[s][way][a[3:2]];
        if (way < 2) begin
            m_root[s] = 1;
            m_left[s] = (way == 0);
        end else begin
            m_root[s] = 0;
            m_right[s] = (way == 2);
        end
    endtask

    task automatic do_access(input logic [31:0] a, input bit wr, input logic [31:0] wd, input int hold,
                             output logic [31:0] rd, output int lat, output int acks,
                             output int words, output int reqcyc, output time t_ack);
        int base;
        bit seen;
        base = mem_log.size();
        @(negedge clk);
        req_mem_cycles = 0;
        req_cpu2cc  = 1'b1;
        adr_cpu2cc  = a;
        dat_cpu2cc  = wd;
        rdwr_cpu2cc = wr;
        lat = -1; acks = 0; seen = 0; rd = '0; t_ack = 0;
        for (int n = 1; n <= 200; n++) begin
            @(negedge clk);
            if (ack_cc2cpu) begin
                acks++;
                if (!seen) begin
                    seen = 1; lat = n - 1; rd = dat_cc2cpu; t_ack = $time;
                end
            end
            if (seen && n >= lat + 1 + hold) req_cpu2cc = 1'b0;
            if (seen && n >= lat + 4 + hold) break;
        end
        req_cpu2cc = 1'b0;
        if (!seen) begin
            total++; bad++;
            $display("[TB] FAIL ack_timeout addr=%h got no ack required one ack", a);
        end
        words = mem_log.size() - base;
        reqcyc = req_mem_cycles;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (ack_cc2cpu !== 1'b0) begin bad++; $display("[TB] FAIL reset_ack got=%b want=0", ack_cc2cpu); end
        total++; if (dat_cc2cpu !== 32'h0) begin bad++; $display("[TB] FAIL reset_dat got=%h want=0", dat_cc2cpu); end
        total++; if (req_cc2mem !== 1'b0) begin bad++; $display("[TB] FAIL reset_req_mem got=%b want=0", req_cc2mem); end
        total++; if (adr_cc2mem !== 32'h0) begin bad++; $display("[TB] FAIL reset_adr_mem got=%h want=0", adr_cc2mem); end
        total++; if (dat_mem2mshr !== 32'h0) begin bad++; $display("[TB] FAIL reset_mshr_dat got=%h want=0", dat_mem2mshr); end
        total++; if (word_mem2mshr !== 2'd0) begin bad++; $display("[TB] FAIL reset_mshr_word got=%0d want=0", word_mem2mshr); end
        total++; if (dat_cc2mshr !== 128'h0) begin bad++; $display("[TB] FAIL reset_line got=%h want=0", dat_cc2mshr); end
        rst = 1'b0;
        model_reset();
        @(negedge clk);
    endtask

    task automatic test_cold_fill();
        logic [31:0] rd, exp;
        int lat, acks, words, reqcyc, base;
        bit miss;
        time t_ack;
        ovr_en = 1; ovr_base = 32'h10000000;
        base = mem_log.size();
        model_access(ADR_A, 0, '0, exp, miss);
        do_access(ADR_A, 0, '0, 0, rd, lat, acks, words, reqcyc, t_ack);
        total++; if (rd !== 32'h10000002) begin bad++; $display("[TB] FAIL cold_data got=%h want=10000002", rd); end
        total++; if (acks !== 1) begin bad++; $display("[TB] FAIL cold_acks got=%0d want=1", acks); end
        total++; if (words !== 4) begin bad++; $display("[TB] FAIL cold_words got=%0d want=4", words); end
        for (int i = 0; i < 4 && i < words; i++) begin
            total++;
            if (mem_log[base+i] !== 32'hFF07BD00 + 32'(4*i)) begin
                bad++; $display("[TB] FAIL cold_adr%0d got=%h want=%h", i, mem_log[base+i], 32'hFF07BD00 + 32'(4*i));
            end
        end
        total++; if (t_ack - t_last_mem_ack !== 20) begin bad++; $display("[TB] FAIL cold_latency got=%0t want=20", t_ack - t_last_mem_ack); end
        total++;
        if (dat_cc2mshr !== {32'h10000003, 32'h10000002, 32'h10000001, 32'h10000000}) begin
            bad++; $display("[TB] FAIL cold_line got=%h want=10000003100000021000000110000000", dat_cc2mshr);
        end
        total++; if (dat_mem2mshr !== 32'h10000003) begin bad++; $display("[TB] FAIL cold_mshr_dat got=%h want=10000003", dat_mem2mshr); end
        total++; if (word_mem2mshr !== 2'd3) begin bad++; $display("[TB] FAIL cold_mshr_word got=%0d want=3", word_mem2mshr); end
        ovr_en = 0;
    endtask

    task automatic test_fill_ways();
        logic [31:0] addrs [3];
        logic [31:0] rd, exp;
        int lat, acks, words, reqcyc;
        bit miss;
        time t_ack;
        addrs[0] = ADR_B; addrs[1] = ADR_C; addrs[2] = ADR_D;
        for (int i = 0; i < 3; i++) begin
            model_access(addrs[i], 0, '0, exp, miss);
            do_access(addrs[i], 0, '0, 0, rd, lat, acks, words, reqcyc, t_ack);
            total++; if (rd !== exp) begin bad++; $display("[TB] FAIL fill_data%0d got=%h want=%h", i, rd, exp); end
            total++; if (words !== 4) begin bad++; $display("[TB] FAIL fill_words%0d got=%0d want=4", i, words); end
            total++; if (acks !== 1) begin bad++; $display("[TB] FAIL fill_acks%0d got=%0d want=1", i, acks); end
        end
    endtask

    task automatic test_hit_held();
        logic [31:0] rd, exp;
        int lat, acks, words, reqcyc;
        bit miss;
        time t_ack;
        model_access(ADR_A, 0, '0, exp, miss);
        do_access(ADR_A, 0, '0, 3, rd, lat, acks, words, reqcyc, t_ack);
        total++; if (rd !== 32'h10000002) begin bad++; $display("[TB] FAIL hit_data got=%h want=10000002", rd); end
        total++; if (words !== 0) begin bad++; $display("[TB] FAIL hit_words got=%0d want=0", words); end
        total++; if (reqcyc !== 0) begin bad++; $display("[TB] FAIL hit_req_mem got=%0d want=0", reqcyc); end
        total++; if (acks !== 1) begin bad++; $display("[TB] FAIL hit_acks got=%0d want=1", acks); end
        total++; if (lat !== 2) begin bad++; $display("[TB] FAIL hit_latency got=%0d want=2", lat); end
        repeat (2) @(negedge clk);
        total++; if (dat_cc2cpu !== 32'h10000002) begin bad++; $display("[TB] FAIL hit_dat_hold got=%h want=10000002", dat_cc2cpu); end
    endtask

    task automatic test_write_hit();
        logic [31:0] rd, exp;
        int lat, acks, words, reqcyc;
        bit miss;
        time t_ack;
        model_access(ADR_D, 1, 32'hAA8AAAA4, exp, miss);
        do_access(ADR_D, 1, 32'hAA8AAAA4, 0, rd, lat, acks, words, reqcyc, t_ack);
        total++; if (words !== 0) begin bad++; $display("[TB] FAIL wr_words got=%0d want=0", words); end
        total++; if (acks !== 1) begin bad++; $display("[TB] FAIL wr_acks got=%0d want=1", acks); end
        total++; if (lat !== 2) begin bad++; $display("[TB] FAIL wr_latency got=%0d want=2", lat); end
        model_access(ADR_D, 0, '0, exp, miss);
        do_access(ADR_D, 0, '0, 0, rd, lat, acks, words, reqcyc, t_ack);
        total++; if (rd !== 32'hAA8AAAA4) begin bad++; $display("[TB] FAIL wr_readback got=%h want=aa8aaaa4", rd); end
        total++; if (words !== 0) begin bad++; $display("[TB] FAIL wr_readback_words got=%0d want=0", words); end
    endtask

    task automatic test_plru_evict();
        logic [31:0] seq [5];
        logic [31:0] rd, exp;
        int lat, acks, words, reqcyc;
        bit miss;
        time t_ack;
        seq[0] = ADR_E; seq[1] = ADR_B; seq[2] = ADR_A; seq[3] = ADR_C; seq[4] = ADR_D;
        for (int i = 0; i < 5; i++) begin
            model_access(seq[i], 0, '0, exp, miss);
            do_access(seq[i], 0, '0, 0, rd, lat, acks, words, reqcyc, t_ack);
            total++; if (words !== (miss ? 4 : 0)) begin bad++; $display("[TB] FAIL evict_words%0d got=%0d want=%0d", i, words, miss ? 4 : 0); end
            total++; if (rd !== exp) begin bad++; $display("[TB] FAIL evict_data%0d got=%h want=%h", i, rd, exp); end
        end
    endtask

    task automatic test_random();
        logic [19:0] tags [6];
        logic [7:0]  sets [2];
        logic [31:0] a, wd, rd, exp;
        int lat, acks, words, reqcyc, hold;
        bit miss, wr;
        time t_ack;
        for (int i = 0; i < 6; i++) tags[i] = 20'($urandom);
        sets[0] = 8'hD0; sets[1] = 8'h13;
        for (int i = 0; i < 80; i++) begin
            a    = {tags[$urandom_range(0, 5)], sets[$urandom_range(0, 1)], 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
            wr   = ($urandom_range(0, 9) < 3);
            wd   = $urandom;
            hold = $urandom_range(0, 2);
            model_access(a, wr, wd, exp, miss);
            do_access(a, wr, wd, hold, rd, lat, acks, words, reqcyc, t_ack);
            total++; if (words !== (miss ? 4 : 0)) begin bad++; $display("[TB] FAIL rnd_words%0d addr=%h got=%0d want=%0d", i, a, words, miss ? 4 : 0); end
            total++; if (acks !== 1) begin bad++; $display("[TB] FAIL rnd_acks%0d got=%0d want=1", i, acks); end
            if (!wr) begin
                total++; if (rd !== exp) begin bad++; $display("[TB] FAIL rnd_data%0d addr=%h got=%h want=%h", i, a, rd, exp); end
            end
            if (!miss) begin
                total++; if (lat !== 2) begin bad++; $display("[TB] FAIL rnd_latency%0d got=%0d want=2", i, lat); end
            end
        end
    endtask

    task automatic test_reset_midrefill();
        logic [31:0] rd, exp;
        int lat, acks, words, reqcyc, target;
        bit miss;
        time t_ack;
        target = mem_given + 1;
        mem_stall_after = target;
        @(negedge clk);
        req_cpu2cc = 1'b1; adr_cpu2cc = ADR_A; dat_cpu2cc = '0; rdwr_cpu2cc = 1'b0;
        for (int k = 0; k < 50 && mem_given < target; k++) @(negedge clk);
        @(negedge clk);
        total++; if (adr_cc2mem !== 32'hFF07BD04) begin bad++; $display("[TB] FAIL mid_adr got=%h want=ff07bd04", adr_cc2mem); end
        rst = 1'b1;
        #1;
        total++; if (req_cc2mem !== 1'b0) begin bad++; $display("[TB] FAIL mid_req_mem got=%b want=0", req_cc2mem); end
        total++; if (ack_cc2cpu !== 1'b0) begin bad++; $display("[TB] FAIL mid_ack got=%b want=0", ack_cc2cpu); end
        total++; if (dat_cc2mshr !== 128'h0) begin bad++; $display("[TB] FAIL mid_line got=%h want=0", dat_cc2mshr); end
        req_cpu2cc = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        mem_stall_after = -1;
        model_reset();
        model_access(ADR_A, 0, '0, exp, miss);
        do_access(ADR_A, 0, '0, 0, rd, lat, acks, words, reqcyc, t_ack);
        total++; if (words !== 4) begin bad++; $display("[TB] FAIL mid_reread_words got=%0d want=4", words); end
        total++; if (rd !== exp) begin bad++; $display("[TB] FAIL mid_reread_data got=%h want=%h", rd, exp); end
        model_access(ADR_D, 0, '0, exp, miss);
        do_access(ADR_D, 0, '0, 0, rd, lat, acks, words, reqcyc, t_ack);
        total++; if (words !== 4) begin bad++; $display("[TB] FAIL mid_d_words got=%0d want=4", words); end
        total++; if (rd !== exp) begin bad++; $display("[TB] FAIL mid_d_data got=%h want=%h", rd, exp); end
    endtask

    initial begin
        rst = 1'b1;
        req_cpu2cc = 1'b0;
        adr_cpu2cc = '0;
        dat_cpu2cc = '0;
        rdwr_cpu2cc = 1'b0;
        test_reset();
        test_cold_fill();
        test_fill_ways();
        test_hit_held();
        test_write_hit();
        test_plru_evict();
        test_random();
        test_reset_midrefill();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
